// File: rtl/rs232_pkg.sv
// Shared definitions for the RS232 receive/send pair.
//   rx_state_e   - receiver FSM state encoding
//   sample_point - clocks from start-edge detection to the sample taken half_bits
//                  half-bit periods into a frame, rounded down. Wide intermediate
//                  so large clock frequencies do not overflow.
package rs232_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

  function automatic int unsigned sample_point(input int unsigned clock_freq,
                                               input int unsigned baud_rate,
                                               input int unsigned half_bits);
    longint unsigned num;
    longint unsigned den;
    num = 64'(clock_freq) * 64'(half_bits);
    den = 64'(2) * 64'(baud_rate);
    return 32'(num / den);
  endfunction

endpackage

// File: rtl/rs232_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
//   clock  - sampling clock
//   reset  - synchronous, active-high; both flops load RESET_VALUE
//   d      - asynchronous input
//   q      - synchronized output
module rs232_sync #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/rs232_recv.sv
// RS232 8N1 receiver with a one-byte valid/ready output buffer and CTS flow control.
//   clock       - system clock, rising edge
//   reset       - synchronous, active-high
//   rs232_txd   - asynchronous serial line from the host, idle high
//   rs232_cts_n - clear-to-send, active low; registered copy of valid
//   data        - received byte, stable while valid is high
//   valid       - byte available
//   ready       - consumer accepts on valid && ready
//   error       - (only with RS232_RECV_ERROR_EN) one-cycle pulse on framing error
//                 or on a byte dropped due to overrun
module rs232_recv
  import rs232_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 133000000,
  parameter int unsigned BAUD_RATE  = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rs232_txd,
  output logic       rs232_cts_n,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready
`ifdef RS232_RECV_ERROR_EN
  ,
  output logic       error
`endif
);

  localparam int unsigned START_MID = sample_point(CLOCK_FREQ, BAUD_RATE, 1);
  localparam int unsigned STOP_MID  = sample_point(CLOCK_FREQ, BAUD_RATE, 19);
  localparam int unsigned TIMER_W   = $clog2(STOP_MID + 1);
  localparam int unsigned BIT_POINT [8] = '{
    sample_point(CLOCK_FREQ, BAUD_RATE, 3),
    sample_point(CLOCK_FREQ, BAUD_RATE, 5),
    sample_point(CLOCK_FREQ, BAUD_RATE, 7),
    sample_point(CLOCK_FREQ, BAUD_RATE, 9),
    sample_point(CLOCK_FREQ, BAUD_RATE, 11),
    sample_point(CLOCK_FREQ, BAUD_RATE, 13),
    sample_point(CLOCK_FREQ, BAUD_RATE, 15),
    sample_point(CLOCK_FREQ, BAUD_RATE, 17)
  };

  logic               rxd;
  rx_state_e          state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               cts_n_q;
  logic [1:0]         flush_q;
  logic               armed_q;
  logic               deliver;
  logic               frame_err;
  logic               overrun;

  rs232_sync #(
    .RESET_VALUE(1'b1)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (rs232_txd),
    .q    (rxd)
  );

  // The synchronizer resets to 1, so rxd only reflects the line after two edges.
  // Arming waits for a genuine high on the line, so a line held low through reset
  // is treated as a break rather than a start bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      flush_q <= 2'd0;
      armed_q <= 1'b0;
    end else begin
      if (flush_q != 2'd2) flush_q <= flush_q + 2'd1;
      if (flush_q == 2'd2 && rxd) armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = '0;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    deliver   = 1'b0;
    frame_err = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (armed_q && !rxd) begin
          state_d = StStart;
        end
      end
      StStart: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == TIMER_W'(START_MID)) begin
          if (rxd) begin
            state_d = StIdle;
            timer_d = '0;
          end else begin
            state_d   = StData;
            bit_idx_d = 3'd0;
          end
        end
      end
      StData: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == TIMER_W'(BIT_POINT[bit_idx_q])) begin
          shift_d[bit_idx_q] = rxd;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == TIMER_W'(STOP_MID)) begin
          timer_d = '0;
          if (rxd) begin
            state_d = StIdle;
            deliver = 1'b1;
          end else begin
            state_d   = StBreak;
            frame_err = 1'b1;
          end
        end
      end
      StBreak: begin
        if (rxd) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // One-byte buffer: a delivery lands if the buffer is empty or being drained
  // this same cycle; otherwise the new byte is dropped and the old one kept.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    overrun = deliver && valid_q && !ready;
    if (deliver && (!valid_q || ready)) begin
      valid_d = 1'b1;
      data_d  = shift_q;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      cts_n_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      cts_n_q   <= valid_q;
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign rs232_cts_n = cts_n_q;

`ifdef RS232_RECV_ERROR_EN
  logic error_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      error_q <= 1'b0;
    end else begin
      error_q <= frame_err | overrun;
    end
  end

  assign error = error_q;
`else
  logic unused_err_events;
  assign unused_err_events = frame_err | overrun;
`endif

endmodule

// File: tb/tb_rs232_recv.sv
module tb_rs232_recv;

  localparam int unsigned CLOCK_FREQ = 1050;
  localparam int unsigned BAUD_RATE  = 100;
  localparam int unsigned CPB_NOM    = 10500;  // clocks per bit x1000

  logic       clock;
  logic       reset;
  logic       rs232_txd;
  logic       rs232_cts_n;
  logic [7:0] data;
  logic       valid;
  logic       ready;
`ifdef RS232_RECV_ERROR_EN
  logic       error;
`endif

  int unsigned n_compared;
  int unsigned n_mismatched;
  int unsigned n_err_pulse;
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];

  rs232_recv #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rs232_txd  (rs232_txd),
    .rs232_cts_n(rs232_cts_n),
    .data       (data),
    .valid      (valid),
    .ready      (ready)
`ifdef RS232_RECV_ERROR_EN
    ,
    .error      (error)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record accepted bytes and error pulses away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (valid && ready) rx_q.push_back(data);
`ifdef RS232_RECV_ERROR_EN
      if (error) n_err_pulse++;
`endif
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Ideal transmitter: bit i spans [round(i*cpb), round((i+1)*cpb)) clocks.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int unsigned cpb);
    logic [9:0]  bits;
    int unsigned t;
    bits = {stop_bit, b, 1'b0};
    t    = 0;
    tick();
    for (int i = 0; i < 10; i++) begin
      rs232_txd = bits[i];
      while (t < ((i + 1) * cpb + 500) / 1000) begin
        tick();
        t++;
      end
    end
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, "_byte"}, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int unsigned err_base;
    int unsigned cpb;
    logic [7:0]  b;

    n_compared   = 0;
    n_mismatched = 0;
    n_err_pulse  = 0;
    reset        = 1'b1;
    rs232_txd    = 1'b1;
    ready        = 1'b1;
    idle(4);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'h00);
    check("rst_cts_n", 32'(rs232_cts_n), 32'd1);
    reset = 1'b0;
    idle(10);

    // Latency: valid appears 102 clocks after the first edge seeing the low line.
    fork
      send_frame(8'hA5, 1'b1, CPB_NOM);
      begin
        tick();
        idle(102);
        check("lat_valid_before", 32'(valid), 32'd0);
        tick();
        check("lat_valid_at", 32'(valid), 32'd1);
        check("lat_data", 32'(data), 32'hA5);
        tick();
        check("lat_valid_after", 32'(valid), 32'd0);
      end
    join
    exp_q.push_back(8'hA5);
    idle(20);
    check_stream("a5");

    // Short glitch must not produce a frame.
    err_base  = n_err_pulse;
    rs232_txd = 1'b0;
    idle(3);
    rs232_txd = 1'b1;
    idle(150);
    check("glitch_valid", 32'(valid), 32'd0);
    check_stream("glitch");
    check("glitch_err", n_err_pulse, err_base);

    // Overrun: second byte dropped while the first is held.
    ready    = 1'b0;
    err_base = n_err_pulse;
    send_frame(8'h55, 1'b1, CPB_NOM);
    send_frame(8'h3C, 1'b1, CPB_NOM);
    idle(10);
    check("ovr_valid", 32'(valid), 32'd1);
    check("ovr_data", 32'(data), 32'h55);
    check("ovr_cts_n", 32'(rs232_cts_n), 32'd1);
`ifdef RS232_RECV_ERROR_EN
    check("ovr_err", n_err_pulse, err_base + 1);
`endif
    ready = 1'b1;
    tick();
    check("ovr_valid_fall", 32'(valid), 32'd0);
    check("ovr_cts_lag", 32'(rs232_cts_n), 32'd1);
    tick();
    check("ovr_cts_fall", 32'(rs232_cts_n), 32'd0);
    exp_q.push_back(8'h55);
    idle(5);
    check_stream("ovr");

    // Framing error then a held-low line, then recovery.
    err_base = n_err_pulse;
    send_frame(8'h5A, 1'b0, CPB_NOM);
    idle(200);
    check("brk_valid", 32'(valid), 32'd0);
`ifdef RS232_RECV_ERROR_EN
    check("brk_err", n_err_pulse, err_base + 1);
`endif
    check_stream("brk");
    rs232_txd = 1'b1;
    idle(20);
    send_frame(8'h01, 1'b1, CPB_NOM);
    exp_q.push_back(8'h01);
    idle(20);
    check("rec_data", 32'(data), 32'h01);
    check_stream("rec");

    // Reset near BIT_3 aborts the frame; remaining bits are high so no false start.
    fork
      send_frame(8'hF8, 1'b1, CPB_NOM);
      begin
        tick();
        idle(50);
        reset = 1'b1;
        tick();
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_data", 32'(data), 32'h00);
        check("mid_rst_cts_n", 32'(rs232_cts_n), 32'd1);
        reset = 1'b0;
      end
    join
    idle(30);
    send_frame(8'hFF, 1'b1, CPB_NOM);
    exp_q.push_back(8'hFF);
    idle(20);
    check_stream("post_rst");

    // Baud sweep at +-3%.
    for (int s = 0; s < 2; s++) begin
      cpb = (s == 0) ? 10185 : 10815;
      send_frame(8'h00, 1'b1, cpb);
      exp_q.push_back(8'h00);
      idle(5);
      send_frame(8'hFF, 1'b1, cpb);
      exp_q.push_back(8'hFF);
      idle(5);
    end
    idle(20);
    check_stream("sweep");

    // Random bytes, random baud within +-3%, random idle gaps.
    err_base = n_err_pulse;
    for (int i = 0; i < 16; i++) begin
      b   = 8'($urandom);
      cpb = $urandom_range(10815, 10185);
      send_frame(b, 1'b1, cpb);
      exp_q.push_back(b);
      idle($urandom_range(12, 2));
    end
    idle(20);
    check_stream("rand");
    check("rand_err", n_err_pulse, err_base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
